pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage core. Each cycle it compares the decode-stage source registers against the instruction in execute, and watches the instruction-cache and data-cache miss lines, the execute-stage branch-mispredict signal and the ecall-halt condition. From these it drives the stall and flush enables of the PC register and of every pipeline register, including the decode→execute register's `i_stall_exec`/`i_flush_exec`. It also keeps saturating performance counters for stall cycles and flushes.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HALT = 2'd2
    } hz_state_t;

    localparam int HZ_REG_ADDR_W = 5;
    localparam int HZ_CNT_W      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_r;

    // Count events, stopping at the maximum value instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt_r <= {W{1'b0}};
        end else if (i_inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_cnt = cnt_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage core: load-use bubbles, cache-miss
// freezes, mispredict flushes and ecall halt, plus stall/flush perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int CNT_W      = HZ_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
    input  logic                  i_reg_we_exec,
    input  logic                  i_load_instr_exec,
    input  logic                  i_branch_mispred,
    input  logic                  i_ecall_instr_exec,
    input  logic                  i_a0_reg_lsb_exec,
    input  logic                  i_icache_miss,
    input  logic                  i_dcache_miss,
    output logic                  o_stall_fetch,
    output logic                  o_stall_dec,
    output logic                  o_stall_exec,
    output logic                  o_stall_mem,
    output logic                  o_stall_wb,
    output logic                  o_flush_dec,
    output logic                  o_flush_exec,
    output logic                  o_halt,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    hz_state_t state_r;
    hz_state_t next_state_s;
    logic      halt_r;

    logic lu_s;
    logic miss_s;
    logic hlt_s;
    logic stall_all_s;
    logic stall_front_s;
    logic flush_dec_s;
    logic flush_exec_s;
    logic flush_inc_s;

    // Hazard detection on the decode/execute boundary.
    always_comb begin
        miss_s = i_icache_miss | i_dcache_miss;
        hlt_s  = i_ecall_instr_exec & i_a0_reg_lsb_exec;
        lu_s   = i_load_instr_exec & i_reg_we_exec &
                 (i_rd_addr_exec != {REG_ADDR_W{1'b0}}) &
                 ((i_rd_addr_exec == i_rs1_addr_dec) |
                  (i_rd_addr_exec == i_rs2_addr_dec));
    end

    // Output decode and next state; MISS shares RUN rules on its exit cycle.
    always_comb begin
        stall_all_s   = 1'b0;
        stall_front_s = 1'b0;
        flush_dec_s   = 1'b0;
        flush_exec_s  = 1'b0;
        flush_inc_s   = 1'b0;
        next_state_s  = state_r;
        if (!i_rstn) begin
            next_state_s = RUN;
        end else begin
            case (state_r)
                HALT: begin
                    stall_all_s  = 1'b1;
                    next_state_s = HALT;
                end
                RUN, MISS: begin
                    if (miss_s) begin
                        stall_all_s  = 1'b1;
                        next_state_s = MISS;
                    end else if (i_branch_mispred) begin
                        flush_dec_s  = 1'b1;
                        flush_exec_s = 1'b1;
                        flush_inc_s  = 1'b1;
                        next_state_s = RUN;
                    end else if (hlt_s) begin
                        next_state_s = HALT;
                    end else if (lu_s) begin
                        stall_front_s = 1'b1;
                        flush_exec_s  = 1'b1;
                        next_state_s  = RUN;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // State register and the registered halt flag.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r <= RUN;
            halt_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            halt_r  <= (next_state_s == HALT);
        end
    end

    assign o_stall_fetch = stall_all_s | stall_front_s;
    assign o_stall_dec   = stall_all_s | stall_front_s;
    assign o_stall_exec  = stall_all_s;
    assign o_stall_mem   = stall_all_s;
    assign o_stall_wb    = stall_all_s;
    assign o_flush_dec   = flush_dec_s;
    assign o_flush_exec  = flush_exec_s;
    assign o_halt        = halt_r & i_rstn;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_inc  (o_stall_fetch),
        .o_cnt  (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_inc  (flush_inc_s),
        .o_cnt  (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; a narrow-counter second instance
// exercises counter saturation on the same stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rstn;
    logic [4:0] rs1, rs2, rd;
    logic       we, ld, mp, ec, a0, im, dm;

    logic        s_f, s_d, s_e, s_m, s_w, f_d, f_e, hlt;
    logic [31:0] scnt, fcnt;
    logic        n_s_f, n_s_d, n_s_e, n_s_m, n_s_w, n_f_d, n_f_e, n_hlt;
    logic [2:0]  n_scnt, n_fcnt;

    typedef struct packed {
        logic [4:0]  stall;
        logic [1:0]  flush;
        logic        halt;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic [2:0]  sscnt;
        logic [2:0]  sfcnt;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 RUN, 1 MISS, 2 HALT.
    int          m_st  = 0;
    logic [31:0] m_sc  = 32'd0;
    logic [31:0] m_fc  = 32'd0;
    logic [2:0]  m_ssc = 3'd0;
    logic [2:0]  m_sfc = 3'd0;

    pipeline_hazard_ctrl dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_rs1_addr_dec(rs1), .i_rs2_addr_dec(rs2), .i_rd_addr_exec(rd),
        .i_reg_we_exec(we), .i_load_instr_exec(ld), .i_branch_mispred(mp),
        .i_ecall_instr_exec(ec), .i_a0_reg_lsb_exec(a0),
        .i_icache_miss(im), .i_dcache_miss(dm),
        .o_stall_fetch(s_f), .o_stall_dec(s_d), .o_stall_exec(s_e),
        .o_stall_mem(s_m), .o_stall_wb(s_w),
        .o_flush_dec(f_d), .o_flush_exec(f_e), .o_halt(hlt),
        .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(3)) dut_sat (
        .i_clk(clk), .i_rstn(rstn),
        .i_rs1_addr_dec(rs1), .i_rs2_addr_dec(rs2), .i_rd_addr_exec(rd),
        .i_reg_we_exec(we), .i_load_instr_exec(ld), .i_branch_mispred(mp),
        .i_ecall_instr_exec(ec), .i_a0_reg_lsb_exec(a0),
        .i_icache_miss(im), .i_dcache_miss(dm),
        .o_stall_fetch(n_s_f), .o_stall_dec(n_s_d), .o_stall_exec(n_s_e),
        .o_stall_mem(n_s_m), .o_stall_wb(n_s_w),
        .o_flush_dec(n_f_d), .o_flush_exec(n_f_e), .o_halt(n_hlt),
        .o_stall_cnt(n_scnt), .o_flush_cnt(n_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected combinational outputs for the current model state and inputs.
    task automatic model(output exp_t e, output int nxt, output logic finc);
        logic lu, miss, halt_c;
        e = '0;
        nxt = m_st;
        finc = 1'b0;
        lu = ld && we && (rd != 5'd0) && (rd == rs1 || rd == rs2);
        miss = im || dm;
        halt_c = ec && a0;
        if (!rstn) begin
            nxt = 0;
        end else if (m_st == 2) begin
            e.stall = 5'b11111;
        end else if (miss) begin
            e.stall = 5'b11111;
            nxt = 1;
        end else if (mp) begin
            e.flush = 2'b11;
            finc = 1'b1;
            nxt = 0;
        end else if (halt_c) begin
            nxt = 2;
        end else if (lu) begin
            e.stall = 5'b11000;
            e.flush = 2'b01;
            nxt = 0;
        end else begin
            nxt = 0;
        end
        e.halt  = (m_st == 2) && rstn;
        e.scnt  = m_sc;
        e.fcnt  = m_fc;
        e.sscnt = m_ssc;
        e.sfcnt = m_sfc;
    endtask

    // One clock: push expectation, compare mid-cycle, then advance the model.
    task automatic cycle(input string tag);
        exp_t e, o;
        int nxt;
        logic finc;
        model(e, nxt, finc);
        sb_q.push_back(e);
        #1;
        o = sb_q.pop_front();
        check({tag, ":stall"}, 64'({s_f, s_d, s_e, s_m, s_w}), 64'(o.stall));
        check({tag, ":flush"}, 64'({f_d, f_e}), 64'(o.flush));
        check({tag, ":halt"}, 64'(hlt), 64'(o.halt));
        check({tag, ":scnt"}, 64'(scnt), 64'(o.scnt));
        check({tag, ":fcnt"}, 64'(fcnt), 64'(o.fcnt));
        check({tag, ":sat_scnt"}, 64'(n_scnt), 64'(o.sscnt));
        check({tag, ":sat_fcnt"}, 64'(n_fcnt), 64'(o.sfcnt));
        @(posedge clk);
        if (!rstn) begin
            m_st = 0; m_sc = 32'd0; m_fc = 32'd0; m_ssc = 3'd0; m_sfc = 3'd0;
        end else begin
            m_st = nxt;
            if (o.stall[4]) begin
                if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
                if (m_ssc != 3'd7) m_ssc = m_ssc + 3'd1;
            end
            if (finc) begin
                if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
                if (m_sfc != 3'd7) m_sfc = m_sfc + 3'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0;
        we = 1'b0; ld = 1'b0; mp = 1'b0; ec = 1'b0; a0 = 1'b0; im = 1'b0; dm = 1'b0;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cycle("reset");
        rstn = 1'b1;
        cycle("idle");

        // Load-use on rs2, then the same with rd = x0 and with we = 0.
        ld = 1'b1; we = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
        cycle("lu_rs2");
        idle(); cycle("after_lu");
        ld = 1'b1; we = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        cycle("lu_x0");
        ld = 1'b1; we = 1'b0; rd = 5'd7; rs1 = 5'd7;
        cycle("lu_nowe");
        ld = 1'b1; we = 1'b1; rd = 5'd9; rs1 = 5'd9; rs2 = 5'd4;
        cycle("lu_rs1");

        // Mispredict coincident with load-use.
        mp = 1'b1;
        cycle("mp_lu");
        idle(); cycle("after_mp");

        // Four-cycle dcache miss with mispredict asserted inside it.
        dm = 1'b1; cycle("miss1");
        cycle("miss2");
        mp = 1'b1; cycle("miss3_mp");
        cycle("miss4_mp");
        dm = 1'b0; cycle("miss_exit_mp");
        idle(); cycle("after_miss");

        // ecall without a0[0], then icache miss coincident with halting ecall.
        ec = 1'b1; a0 = 1'b0; cycle("ecall_nohalt");
        idle(); cycle("after_ecall");
        ec = 1'b1; a0 = 1'b1; im = 1'b1; cycle("miss_hlt");
        im = 1'b0; cycle("hlt_exit_miss");
        idle();
        for (int i = 0; i < 100; i++) begin
            if (i == 50) mp = 1'b1;
            cycle("halted");
        end
        idle();

        // Reset out of HALT, then reset in the middle of a miss.
        rstn = 1'b0; cycle("rst_halt");
        rstn = 1'b1; cycle("run_after_halt");
        dm = 1'b1; cycle("miss_a");
        cycle("miss_b");
        rstn = 1'b0; cycle("rst_in_miss");
        rstn = 1'b1; dm = 1'b0; cycle("run_after_rst");
        ld = 1'b1; we = 1'b1; rd = 5'd5; rs2 = 5'd5; cycle("lu_post_rst");
        idle(); cycle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
